// File: rtl/fm_demodulator.sv
// fm_demodulator: recovers the modulating signal from an offset-binary FM
// sample stream by timing rising midscale crossings (with hysteresis),
// averaging the last few carrier periods and reporting the deviation from a
// nominal period as an offset-binary sample.
module fm_demodulator #(
    parameter int HYST       = 16,
    parameter int MAX_PERIOD = 65535,
    parameter int AVG_LOG2   = 2,
    parameter int GAIN_SHIFT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  in_sample,
    input  logic        in_valid,
    input  logic [15:0] ref_period,
    output logic [9:0]  demod_out,
    output logic        demod_valid,
    output logic [15:0] period_out,
    output logic        locked
);

    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SUM_W = 16 + AVG_LOG2;
    localparam int DEV_W = 18 + GAIN_SHIFT + 1;

    localparam logic [10:0]       HIGH_TH  = 11'(512 + HYST);
    localparam logic [10:0]       LOW_TH   = 11'(511 - HYST);
    localparam logic [15:0]       CNT_LAST = 16'(MAX_PERIOD - 1);
    localparam logic [AVG_LOG2:0] CAP_FULL = (AVG_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {
        HUNT      = 2'd0,
        ARM       = 2'd1,
        WAIT_LOW  = 2'd2,
        WAIT_HIGH = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [15:0]        hist_q [DEPTH];
    logic [15:0]        hist_d [DEPTH];
    logic [AVG_LOG2:0]  cap_q, cap_d;
    logic               locked_q, locked_d;
    logic               pend_q, pend_d;
    logic [9:0]         demod_q, demod_d;
    logic               valid_q, valid_d;
    logic [15:0]        period_q, period_d;

    logic               is_high;
    logic               is_low;
    logic               rec_valid;
    logic [15:0]        rec_period;
    logic               timeout;

    logic [SUM_W-1:0]        sum;
    logic [15:0]             avg;
    logic signed [17:0]      dev18;
    logic signed [DEV_W-1:0] dev_ext;
    logic signed [DEV_W-1:0] dev_sh;
    logic signed [DEV_W-1:0] out_wide;
    logic [9:0]              out_sat;

    // Classify the incoming sample against the hysteresis band around midscale.
    always_comb begin
        is_high = ({1'b0, in_sample} >= HIGH_TH);
        is_low  = ({1'b0, in_sample} <= LOW_TH);
    end

    // Crossing detector and period counter; a timeout drops back to hunting.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rec_valid  = 1'b0;
        rec_period = cnt_q + 16'd1;
        timeout    = 1'b0;
        if (in_valid) begin
            case (state_q)
                HUNT: begin
                    if (is_low) begin
                        state_d = ARM;
                    end
                end
                ARM: begin
                    if (is_high) begin
                        cnt_d   = 16'd0;
                        state_d = WAIT_LOW;
                    end
                end
                WAIT_LOW: begin
                    if (cnt_q == CNT_LAST) begin
                        timeout = 1'b1;
                        cnt_d   = 16'd0;
                        state_d = HUNT;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                        if (is_low) begin
                            state_d = WAIT_HIGH;
                        end
                    end
                end
                WAIT_HIGH: begin
                    if (is_high) begin
                        rec_valid = 1'b1;
                        cnt_d     = 16'd0;
                        state_d   = WAIT_LOW;
                    end else if (cnt_q == CNT_LAST) begin
                        timeout = 1'b1;
                        cnt_d   = 16'd0;
                        state_d = HUNT;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_d = HUNT;
                    cnt_d   = 16'd0;
                end
            endcase
        end
    end

    // Period history shift register and captured-period count that drives lock.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            hist_d[i] = hist_q[i];
        end
        cap_d  = cap_q;
        pend_d = 1'b0;
        if (timeout) begin
            for (int i = 0; i < DEPTH; i++) begin
                hist_d[i] = 16'd0;
            end
            cap_d = '0;
        end else if (rec_valid) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                hist_d[i] = hist_q[i - 1];
            end
            hist_d[0] = rec_period;
            if (cap_q != CAP_FULL) begin
                cap_d = cap_q + 1'b1;
            end
            pend_d = 1'b1;
        end
        locked_d = (cap_d == CAP_FULL);
    end

    // Average the history and turn the period error into a saturated sample.
    always_comb begin
        sum = '0;
        for (int i = 0; i < DEPTH; i++) begin
            sum = sum + SUM_W'(hist_q[i]);
        end
        avg      = 16'(sum >> AVG_LOG2);
        dev18    = $signed({2'b00, ref_period}) - $signed({2'b00, avg});
        dev_ext  = {{(DEV_W - 18){dev18[17]}}, dev18};
        dev_sh   = dev_ext <<< GAIN_SHIFT;
        out_wide = dev_sh + $signed(DEV_W'(512));
        if (out_wide[DEV_W-1]) begin
            out_sat = 10'd0;
        end else if (out_wide > $signed(DEV_W'(1023))) begin
            out_sat = 10'd1023;
        end else begin
            out_sat = out_wide[9:0];
        end
    end

    // Output stage: publish one cycle after a recorded period, only while locked.
    always_comb begin
        demod_d  = demod_q;
        valid_d  = 1'b0;
        period_d = period_q;
        if (timeout) begin
            demod_d = 10'd512;
        end else if (pend_q && locked_q) begin
            demod_d  = out_sat;
            valid_d  = 1'b1;
            period_d = avg;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= HUNT;
            cnt_q    <= 16'd0;
            for (int i = 0; i < DEPTH; i++) begin
                hist_q[i] <= 16'd0;
            end
            cap_q    <= '0;
            locked_q <= 1'b0;
            pend_q   <= 1'b0;
            demod_q  <= 10'd512;
            valid_q  <= 1'b0;
            period_q <= 16'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            for (int i = 0; i < DEPTH; i++) begin
                hist_q[i] <= hist_d[i];
            end
            cap_q    <= cap_d;
            locked_q <= locked_d;
            pend_q   <= pend_d;
            demod_q  <= demod_d;
            valid_q  <= valid_d;
            period_q <= period_d;
        end
    end

    assign demod_out   = demod_q;
    assign demod_valid = valid_q;
    assign period_out  = period_q;
    assign locked      = locked_q;

endmodule

// File: tb/tb_fm_demodulator.sv
// tb_fm_demodulator: drives two demodulator instances (short timeout, and
// gain shift 4) with square waves, strobe gaps, resets and random samples,
// comparing every cycle against an index-based reference model.
module tb_fm_demodulator;

    localparam int HYST = 16;

    logic        clk;
    logic        rst_n = 1'b1;
    logic [9:0]  in_sample;
    logic        in_valid;
    logic [15:0] ref_period;

    logic [9:0]  out_a, out_b;
    logic        dv_a, dv_b;
    logic [15:0] per_a, per_b;
    logic        lock_a, lock_b;

    int total = 0;
    int bad   = 0;
    int pulse_a;

    // Reference model state, index 0 = dut_a, 1 = dut_b
    int m_out [2];
    int m_period [2];
    bit m_valid [2];
    bit m_locked [2];
    bit seen_low [2];
    bit have_ref [2];
    bit pend [2];
    int ref_idx [2];
    int hist [2][4];
    int hcnt [2];
    int n = 0;

    typedef struct {
        int hi_len;
        int lo_len;
        int refp;
        int exp_out_a;
        int exp_out_b;
        int exp_period;
    } vec_t;

    vec_t vecs [8];

    fm_demodulator #(.HYST(HYST), .MAX_PERIOD(64), .AVG_LOG2(2), .GAIN_SHIFT(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_sample(in_sample), .in_valid(in_valid),
        .ref_period(ref_period), .demod_out(out_a), .demod_valid(dv_a),
        .period_out(per_a), .locked(lock_a));

    fm_demodulator #(.HYST(HYST), .MAX_PERIOD(65535), .AVG_LOG2(2), .GAIN_SHIFT(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_sample(in_sample), .in_valid(in_valid),
        .ref_period(ref_period), .demod_out(out_b), .demod_valid(dv_b),
        .period_out(per_b), .locked(lock_b));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int maxp(input int m);
        return (m == 0) ? 64 : 65535;
    endfunction

    function automatic int gsh(input int m);
        return (m == 0) ? 0 : 4;
    endfunction

    task automatic modelReset();
        for (int m = 0; m < 2; m++) begin
            m_out[m] = 512; m_period[m] = 0; m_valid[m] = 0; m_locked[m] = 0;
            seen_low[m] = 0; have_ref[m] = 0; pend[m] = 0; ref_idx[m] = 0;
            hcnt[m] = 0;
            for (int k = 0; k < 4; k++) hist[m][k] = 0;
        end
    endtask

    // Periods are differences of valid-sample indices between rising crossings
    task automatic modelStep(input int smp, input bit vld, input int refp);
        bit hi, lo;
        int sum, avg, o;
        hi = (smp >= 512 + HYST);
        lo = (smp <= 511 - HYST);
        for (int m = 0; m < 2; m++) begin
            m_valid[m] = 0;
            if (pend[m] && m_locked[m]) begin
                sum = 0;
                for (int k = 0; k < 4; k++) sum += hist[m][k];
                avg = sum / 4;
                o = 512 + (refp - avg) * (1 << gsh(m));
                if (o < 0) o = 0;
                if (o > 1023) o = 1023;
                m_out[m] = o;
                m_period[m] = avg;
                m_valid[m] = 1;
            end
            pend[m] = 0;
            if (vld) begin
                if (hi && seen_low[m]) begin
                    if (have_ref[m]) begin
                        for (int k = 3; k > 0; k--) hist[m][k] = hist[m][k-1];
                        hist[m][0] = n - ref_idx[m];
                        if (hcnt[m] < 4) hcnt[m]++;
                        m_locked[m] = (hcnt[m] == 4);
                        pend[m] = 1;
                    end
                    have_ref[m] = 1;
                    ref_idx[m] = n;
                    seen_low[m] = 0;
                end else if (have_ref[m] && (n - ref_idx[m]) >= maxp(m)) begin
                    have_ref[m] = 0; seen_low[m] = 0; hcnt[m] = 0; m_locked[m] = 0;
                    for (int k = 0; k < 4; k++) hist[m][k] = 0;
                    m_out[m] = 512;
                end else if (lo) begin
                    seen_low[m] = 1;
                end
            end
        end
        if (vld) n++;
    endtask

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        checkVal("out_a", 32'(out_a), m_out[0]);
        checkVal("dv_a", 32'(dv_a), 32'(m_valid[0]));
        checkVal("per_a", 32'(per_a), m_period[0]);
        checkVal("lock_a", 32'(lock_a), 32'(m_locked[0]));
        checkVal("out_b", 32'(out_b), m_out[1]);
        checkVal("dv_b", 32'(dv_b), 32'(m_valid[1]));
        checkVal("per_b", 32'(per_b), m_period[1]);
        checkVal("lock_b", 32'(lock_b), 32'(m_locked[1]));
    endtask

    // One clock: present inputs, take the edge, step the model, compare
    task automatic applyStimulus(input int smp, input bit vld, input int refp);
        in_sample  = 10'(smp);
        in_valid   = vld;
        ref_period = 16'(refp);
        @(posedge clk);
        #1;
        modelStep(smp, vld, refp);
        checkOutput();
        if (dv_a) pulse_a++;
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once
    task automatic doReset();
        rst_n = 1'b0;
        #2;
        modelReset();
        checkVal("rst_out_a", 32'(out_a), 512);
        checkVal("rst_dv_a", 32'(dv_a), 0);
        checkVal("rst_per_a", 32'(per_a), 0);
        checkVal("rst_lock_a", 32'(lock_a), 0);
        checkVal("rst_out_b", 32'(out_b), 512);
        checkVal("rst_lock_b", 32'(lock_b), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic squareWave(input int hi, input int lo, input int refp, input int nper, input bit gap);
        for (int p = 0; p < nper; p++) begin
            for (int i = 0; i < hi + lo; i++) begin
                applyStimulus((i < hi) ? 1000 : 24, 1'b1, refp);
                if (gap) applyStimulus(int'($urandom_range(0, 1023)), 1'b0, refp);
            end
        end
    endtask

    initial begin
        int mode, hl, cnt, refp, smp;
        bit vld;
        in_sample = 10'd512; in_valid = 1'b0; ref_period = 16'd8;
        modelReset();
        #1;
        doReset();

        vecs[0] = '{4, 4, 8, 512, 512, 8};
        vecs[1] = '{3, 3, 8, 514, 544, 6};
        vecs[2] = '{4, 4, 2000, 1023, 1023, 8};
        vecs[3] = '{4, 4, 5, 509, 464, 8};
        vecs[4] = '{5, 5, 12, 514, 544, 10};
        vecs[5] = '{2, 2, 4, 512, 512, 4};
        vecs[6] = '{6, 2, 9, 513, 528, 8};
        vecs[7] = '{10, 10, 30, 522, 672, 20};

        for (int v = 0; v < 8; v++) begin
            doReset();
            squareWave(vecs[v].hi_len, vecs[v].lo_len, vecs[v].refp, 8, 1'b0);
            pulse_a = 0;
            squareWave(vecs[v].hi_len, vecs[v].lo_len, vecs[v].refp, 4, 1'b0);
            checkVal("vec_pulses_a", 32'(pulse_a), 4);
            checkVal("vec_out_a", 32'(out_a), vecs[v].exp_out_a);
            checkVal("vec_out_b", 32'(out_b), vecs[v].exp_out_b);
            checkVal("vec_per_a", 32'(per_a), vecs[v].exp_period);
            checkVal("vec_lock_a", 32'(lock_a), 1);
        end

        // Hysteresis band samples never cross; dut_a times out on the 64th sample
        doReset();
        squareWave(4, 4, 10, 8, 1'b0);
        checkVal("to_pre_out_a", 32'(out_a), 514);
        pulse_a = 0;
        for (int i = 0; i < 56; i++) applyStimulus((i % 2) ? 519 : 505, 1'b1, 10);
        checkVal("to_still_locked", 32'(lock_a), 1);
        applyStimulus(505, 1'b1, 10);
        checkVal("to_unlocked", 32'(lock_a), 0);
        checkVal("to_out_a", 32'(out_a), 512);
        for (int i = 0; i < 20; i++) applyStimulus((i % 2) ? 519 : 505, 1'b1, 10);
        checkVal("to_no_pulse", 32'(pulse_a), 0);
        checkVal("to_per_hold", 32'(per_a), 8);
        checkVal("to_lock_b", 32'(lock_b), 1);
        checkVal("to_out_b", 32'(out_b), 544);

        // Long period: low saturation on dut_b, dut_a keeps timing out
        doReset();
        squareWave(500, 500, 2, 6, 1'b0);
        checkVal("sat_out_b", 32'(out_b), 0);
        checkVal("sat_per_b", 32'(per_b), 1000);
        checkVal("sat_lock_a", 32'(lock_a), 0);
        checkVal("sat_out_a", 32'(out_a), 512);

        // Strobe gaps must not change the measured period
        doReset();
        squareWave(4, 4, 8, 12, 1'b1);
        checkVal("gap_per_a", 32'(per_a), 8);
        checkVal("gap_out_a", 32'(out_a), 512);
        checkVal("gap_out_b", 32'(out_b), 512);

        // Mid-lock reset: relock needs four full periods after the first event
        doReset();
        squareWave(4, 4, 8, 7, 1'b0);
        checkVal("ml_locked", 32'(lock_a), 1);
        applyStimulus(1000, 1'b1, 8);
        doReset();
        squareWave(4, 4, 8, 5, 1'b0);
        checkVal("ml_not_yet", 32'(lock_a), 0);
        applyStimulus(1000, 1'b1, 8);
        checkVal("ml_relock", 32'(lock_a), 1);

        // Randomised stream in segments of differing character
        doReset();
        refp = 8; hl = 4; cnt = 0;
        for (int s = 0; s < 60; s++) begin
            mode = int'($urandom_range(0, 2));
            if ($urandom_range(0, 2) == 0) refp = int'($urandom_range(0, 65535));
            else refp = int'($urandom_range(1, 40));
            hl = int'($urandom_range(1, 12));
            for (int i = 0; i < 50; i++) begin
                vld = ($urandom_range(0, 3) != 0);
                case (mode)
                    0: smp = int'($urandom_range(0, 1023));
                    1: begin
                        case ($urandom_range(0, 5))
                            0: smp = 495;
                            1: smp = 496;
                            2: smp = 527;
                            3: smp = 528;
                            default: smp = int'($urandom_range(496, 527));
                        endcase
                    end
                    default: begin
                        smp = (cnt < hl) ? int'($urandom_range(528, 1023)) : int'($urandom_range(0, 495));
                        if (vld) cnt = (cnt + 1) % (2 * hl);
                    end
                endcase
                applyStimulus(smp, vld, refp);
            end
            if (s == 30) doReset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
